// File: rtl/ame_linear_solver_if.sv
// Handshake bundle of the affine-motion linear solver:
// system in (valid/ready), solution out (valid/ready).
interface ame_linear_solver_if #(
  parameter int N         = 6,
  parameter int DATA_BITS = 64
);
  localparam int IDX_BITS = $clog2(N);

  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [IDX_BITS-1:0]           first_i;
  logic [N*(N+1)*DATA_BITS-1:0]  mat_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic                          singular_o;
  logic [N*DATA_BITS-1:0]        x_o;
  logic                          busy_o;

  modport slave (
    input  in_valid_i, first_i, mat_i, out_ready_i,
    output in_ready_o, out_valid_o, singular_o, x_o, busy_o
  );

  modport master (
    output in_valid_i, first_i, mat_i, out_ready_i,
    input  in_ready_o, out_valid_o, singular_o, x_o, busy_o
  );
endinterface

// File: rtl/ame_linear_solver.sv
// Gauss-Jordan solver for an N x (N+1) fixed-point augmented system.
// Partial pivoting, per-step normalisation, shared serial divider.
module ame_linear_solver #(
  parameter int N         = 6,
  parameter int DATA_BITS = 64,
  parameter int FRAC_BITS = 4
) (
  input logic clk_i,
  input logic rst_n_i,
  ame_linear_solver_if.slave bus
);
  localparam int IDX_BITS = $clog2(N);
  localparam int KW = IDX_BITS + 1;
  localparam int DB = DATA_BITS;
  localparam int RW = DB + 1;
  localparam int CW = $clog2(DB + 2);
  localparam int SW = $clog2(DB);
  localparam int HB = DB / 2 - 2;

  typedef logic signed [DB-1:0] word_t;
  typedef logic [DB-1:0] mag_t;
  typedef enum logic [2:0] {
    S_IDLE, S_PIVOT, S_ELIM, S_NORM, S_DIV, S_OUT
  } state_t;

  function automatic mag_t f_abs(input word_t v);
    return v[DB-1] ? mag_t'(-v) : mag_t'(v);
  endfunction

  function automatic logic [IDX_BITS-1:0] f_ix(
    input logic [KW-1:0] v
  );
    return (v < KW'(N)) ? v[IDX_BITS-1:0] : '0;
  endfunction

  state_t              r_state, w_next;
  word_t               r_a [N][N+1];
  word_t               r_q [N];
  logic [IDX_BITS-1:0] r_piv [N];
  logic [N-1:0]        r_used;
  logic [KW-1:0]       r_first, r_k, r_row, r_c;
  logic [IDX_BITS-1:0] r_p;
  logic                r_sing, r_out_valid, r_sing_o;
  logic [N*DB-1:0]     r_x;
  mag_t                r_dq, r_dd;
  logic [DB:0]         r_rem;
  logic                r_dneg;
  logic [CW-1:0]       r_dcnt;

  logic [IDX_BITS-1:0] w_kc, w_rc, w_prow, w_drow;
  mag_t                w_pmax, w_or;
  logic [KW-1:0]       w_row0, w_rown;
  word_t               w_elim [N+1];
  logic [SW-1:0]       w_msb, w_shift;
  word_t               w_num, w_den, w_qres;
  logic [DB+1:0]       w_sh;
  logic                w_ge;

  assign w_kc = f_ix(r_k);
  assign w_rc = f_ix(r_row);

  // Pivot: largest magnitude among unused active rows, lowest row on ties.
  always_comb begin
    w_pmax = '0;
    w_prow = '0;
    for (int r = 0; r < N; r++) begin
      if (r >= int'(r_first) && !r_used[r] &&
          f_abs(r_a[r][w_kc]) > w_pmax) begin
        w_pmax = f_abs(r_a[r][w_kc]);
        w_prow = IDX_BITS'(r);
      end
    end
  end

  always_comb begin
    w_row0 = r_first;
    if (KW'(w_prow) == r_first) w_row0 = r_first + 1'b1;
    w_rown = r_row + 1'b1;
    if (w_rown == KW'(r_p)) w_rown = r_row + KW'(2);
  end

  always_comb begin
    for (int j = 0; j <= N; j++) begin
      w_elim[j] = r_a[w_rc][j] * r_a[r_p][w_kc]
                - r_a[r_p][j] * r_a[w_rc][w_kc];
    end
  end

  // Keep active magnitudes below 2^(DB/2-1) so the next products fit.
  always_comb begin
    w_or = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c <= N; c++) begin
        if (r >= int'(r_first) && c >= int'(r_first))
          w_or = w_or | f_abs(r_a[r][c]);
      end
    end
    w_msb = '0;
    for (int b = 0; b < DB; b++) begin
      if (w_or[b]) w_msb = SW'(b);
    end
    w_shift = (w_msb > SW'(HB)) ? w_msb - SW'(HB) : '0;
  end

  assign w_drow = r_piv[f_ix(r_c)];
  assign w_den  = r_a[w_drow][f_ix(r_c)];
  assign w_num  = {r_a[w_drow][N][DB-FRAC_BITS-1:0],
                   {FRAC_BITS{1'b0}}};
  assign w_sh   = {r_rem, r_dq[DB-1]};
  assign w_ge   = w_sh >= {2'b00, r_dd};

  always_comb begin
    if (r_dneg)
      w_qres = word_t'(-r_dq);
    else if (r_dq[DB-1])
      w_qres = {1'b0, {(DB-1){1'b1}}};
    else
      w_qres = word_t'(r_dq);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid_i) w_next = S_PIVOT;
      S_PIVOT: begin
        if (w_pmax == '0)          w_next = S_OUT;
        else if (w_row0 >= KW'(N)) w_next = S_NORM;
        else                       w_next = S_ELIM;
      end
      S_ELIM:  if (w_rown >= KW'(N)) w_next = S_NORM;
      S_NORM:  w_next = (r_k + 1'b1 == KW'(N)) ? S_DIV : S_PIVOT;
      S_DIV: begin
        if (r_dcnt == CW'(DB + 1) && r_c == KW'(N - 1))
          w_next = S_OUT;
      end
      S_OUT:   if (r_out_valid && bus.out_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c <= N; c++) r_a[r][c] <= '0;
        r_q[r]   <= '0;
        r_piv[r] <= '0;
      end
      r_used      <= '0;
      r_first     <= '0;
      r_k         <= '0;
      r_row       <= '0;
      r_c         <= '0;
      r_p         <= '0;
      r_sing      <= 1'b0;
      r_out_valid <= 1'b0;
      r_sing_o    <= 1'b0;
      r_x         <= '0;
      r_dq        <= '0;
      r_dd        <= '0;
      r_rem       <= '0;
      r_dneg      <= 1'b0;
      r_dcnt      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid_i) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c <= N; c++)
                r_a[r][c] <= bus.mat_i[(r*(N+1)+c)*DB +: DB];
              r_q[r] <= '0;
            end
            r_first <= KW'(bus.first_i);
            r_k     <= KW'(bus.first_i);
            r_used  <= '0;
            r_sing  <= 1'b0;
            r_dcnt  <= '0;
          end
        end
        S_PIVOT: begin
          if (w_pmax == '0) begin
            r_sing <= 1'b1;
          end else begin
            r_used[w_prow] <= 1'b1;
            r_piv[w_kc]    <= w_prow;
            r_p            <= w_prow;
            r_row          <= w_row0;
          end
        end
        S_ELIM: begin
          for (int j = 0; j <= N; j++) begin
            if (j >= int'(r_first)) r_a[w_rc][j] <= w_elim[j];
          end
          r_row <= w_rown;
        end
        S_NORM: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c <= N; c++) begin
              if (r >= int'(r_first) && c >= int'(r_first))
                r_a[r][c] <= r_a[r][c] >>> w_shift;
            end
          end
          r_k    <= r_k + 1'b1;
          r_c    <= r_first;
          r_dcnt <= '0;
        end
        S_DIV: begin
          if (r_dcnt == '0) begin
            r_dq   <= f_abs(w_num);
            r_dd   <= f_abs(w_den);
            r_rem  <= '0;
            r_dneg <= w_num[DB-1] ^ w_den[DB-1];
            r_dcnt <= CW'(1);
          end else if (r_dcnt == CW'(DB + 1)) begin
            r_q[f_ix(r_c)] <= w_qres;
            r_c            <= r_c + 1'b1;
            r_dcnt         <= '0;
          end else begin
            r_rem  <= w_ge ? RW'(w_sh - {2'b00, r_dd}) : w_sh[DB:0];
            r_dq   <= {r_dq[DB-2:0], w_ge};
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_sing_o    <= r_sing;
            for (int c = 0; c < N; c++)
              r_x[c*DB +: DB] <= r_sing ? '0 : r_q[c];
          end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == S_IDLE);
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.out_valid_o = r_out_valid;
  assign bus.singular_o  = r_sing_o;
  assign bus.x_o         = r_x;
endmodule

// File: tb/tb_ame_linear_solver.sv
// Directed bench for ame_linear_solver: vector table plus
// output-hold, busy-ignore and mid-solve reset sequences.
module tb_ame_linear_solver;
  localparam int N  = 6;
  localparam int DB = 64;
  localparam int MW = N * (N + 1) * DB;
  localparam int XW = N * DB;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ame_linear_solver_if #(.N(N), .DATA_BITS(DB)) bus ();

  ame_linear_solver #(
    .N(N), .DATA_BITS(DB), .FRAC_BITS(4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct {
    string          name;
    logic [2:0]     first;
    logic [MW-1:0]  mat;
    logic [XW-1:0]  x;
    logic           sing;
    int             lat;
  } vec_t;

  vec_t          tv [NV];
  logic [MW-1:0] m;
  logic [XW-1:0] xe;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc;

  task automatic setm(input int r, input int c, input logic [63:0] v);
    m[(r*(N+1)+c)*DB +: DB] = v;
  endtask

  task automatic setx(input int c, input logic [63:0] v);
    xe[c*DB +: DB] = v;
  endtask

  task automatic addv(input int i, input string nm, input logic [2:0] f,
                      input logic s, input int lat);
    tv[i].name  = nm;
    tv[i].first = f;
    tv[i].mat   = m;
    tv[i].x     = xe;
    tv[i].sing  = s;
    tv[i].lat   = lat;
    m  = '0;
    xe = '0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, $signed(act),
               $signed(exp));
    end
  endtask

  task automatic start(input int i);
    @(negedge clk);
    chk({tv[i].name, " in_ready"}, 64'(bus.in_ready_o), 64'd1);
    bus.first_i    = tv[i].first;
    bus.mat_i      = tv[i].mat;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid_o && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_out(input int i, input int n);
    chk({tv[i].name, " latency"}, 64'(n), 64'(tv[i].lat));
    chk({tv[i].name, " singular"}, 64'(bus.singular_o),
        64'(tv[i].sing));
    for (int c = 0; c < N; c++)
      chk($sformatf("%s x%0d", tv[i].name, c),
          bus.x_o[c*DB +: DB], tv[i].x[c*DB +: DB]);
  endtask

  task automatic handshake(input string nm);
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    chk({nm, " out_valid drop"}, 64'(bus.out_valid_o), 64'd0);
    chk({nm, " in_ready back"}, 64'(bus.in_ready_o), 64'd1);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.first_i     = '0;
    bus.mat_i       = '0;
    m  = '0;
    xe = '0;

    for (int r = 0; r < N; r++) begin
      setm(r, r, 1);
      setm(r, N, r + 1);
      setx(r, 16 * (r + 1));
    end
    addv(0, "ident", 3'd0, 1'b0, 439);

    setm(0, 0, 7); setm(0, N, 5); setm(1, 3, 9); setm(3, 0, 11);
    setm(2, 2, 2);  setm(2, N, 4);
    setm(3, 3, 4);  setm(3, N, 8);
    setm(4, 4, -8); setm(4, N, 8);
    setm(5, 5, 16); setm(5, N, -32);
    setx(2, 32); setx(3, 32); setx(4, -16); setx(5, -32);
    addv(1, "diag", 3'd2, 1'b0, 285);

    setm(4, 5, 1); setm(5, 4, 1); setm(4, N, 3); setm(5, N, 5);
    setx(4, 80); setx(5, 48);
    addv(2, "swap", 3'd4, 1'b0, 139);

    for (int r = 0; r < N; r++) begin
      if (r != 3) setm(r, r, 1);
      setm(r, N, (r == 3) ? 3 : r + 1);
    end
    setm(3, 2, 1);
    addv(3, "duprow", 3'd0, 1'b1, 23);

    addv(4, "zero", 3'd0, 1'b1, 2);

    for (int r = 0; r < N; r++) setm(r, r, 1);
    addv(5, "first6", 3'd6, 1'b1, 2);

    setm(5, 5, -3); setm(5, N, 7); setx(5, -37);
    addv(6, "negdiv", 3'd5, 1'b0, 69);

    setm(5, 5, 64'shC000_0000_0000_0000);
    setm(5, N, 64'sh0800_0000_0000_0000);
    setx(5, -2);
    addv(7, "norm", 3'd5, 1'b0, 69);

    #12;
    chk("rst in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst busy", 64'(bus.busy_o), 64'd0);
    chk("rst out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst singular", 64'(bus.singular_o), 64'd0);
    chk("rst x_o", 64'(|bus.x_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      start(i);
      wait_out(cyc);
      check_out(i, cyc);
      handshake(tv[i].name);
    end

    // Busy pulses must be ignored, output must hold under back-pressure.
    start(2);
    cyc = 0;
    while (!bus.out_valid_o && cyc < 1000) begin
      bus.first_i    = 3'd0;
      bus.mat_i      = tv[0].mat;
      bus.in_valid_i = (cyc % 5 == 2);
      if (cyc == 40) begin
        chk("busy in_ready", 64'(bus.in_ready_o), 64'd0);
        chk("busy busy_o", 64'(bus.busy_o), 64'd1);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    check_out(2, cyc);
    for (int h = 0; h < 10; h++) begin
      bus.in_valid_i = 1'b1;
      @(posedge clk);
      #1;
      chk("hold out_valid", 64'(bus.out_valid_o), 64'd1);
      chk("hold in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("hold x4", bus.x_o[4*DB +: DB], tv[2].x[4*DB +: DB]);
      chk("hold x5", bus.x_o[5*DB +: DB], tv[2].x[5*DB +: DB]);
    end
    bus.in_valid_i = 1'b0;
    handshake("hold");

    // Abort in the middle of the first elimination pass.
    start(0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst busy", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("abort busy", 64'(bus.busy_o), 64'd0);
    chk("abort in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("abort singular", 64'(bus.singular_o), 64'd0);
    chk("abort x_o", 64'(|bus.x_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start(0);
    wait_out(cyc);
    check_out(0, cyc);
    handshake("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
